// File: rtl/wrport_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wrport_arbiter
//  Purpose  : Shares one RAM write agent port between NB_REQ requesters.
//             Single-beat requests are served round-robin. A multi-beat
//             request locks the port to its owner until its last beat.
//             Accepted beats reach the RAM port one cycle later through
//             registers.
//  Revision : 1.0 - initial release
//
//  Optional feature (compile-time macro):
//    WRPORT_ARBITER_TIMEOUT_EN - a locked burst is cut off once it reaches
//    MAX_BURST beats. The port is then released and burst_abort pulses.
//
//  Ports
//    aclk        in   1                     clock, rising edge
//    aresetn     in   1                     synchronous active-low reset
//    req_valid   in   NB_REQ                per-requester beat valid
//    req_ready   out  NB_REQ                per-requester beat accept
//    req_last    in   NB_REQ                last beat of requester burst
//    req_addr    in   NB_REQ*ADDR_WIDTH     packed, requester i at [i*AW +: AW]
//    req_data    in   NB_REQ*DATA_WIDTH     packed, requester i at [i*DW +: DW]
//    wren        out  1                     RAM write enable
//    wraddr      out  ADDR_WIDTH            RAM write address
//    wrdata      out  DATA_WIDTH            RAM write data
//    grant_id    out  clog2(NB_REQ)         requester of the beat on wren
//    locked      out  1                     port locked to a burst owner
//    burst_abort out  1                     one-cycle pulse on forced release
// ============================================================================
module wrport_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int NB_REQ     = 4,
    parameter int MAX_BURST  = 16
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [NB_REQ-1:0]              req_valid,
    output logic [NB_REQ-1:0]              req_ready,
    input  logic [NB_REQ-1:0]              req_last,
    input  logic [NB_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NB_REQ*DATA_WIDTH-1:0]   req_data,
    output logic                           wren,
    output logic [ADDR_WIDTH-1:0]          wraddr,
    output logic [DATA_WIDTH-1:0]          wrdata,
    output logic [$clog2(NB_REQ)-1:0]      grant_id,
    output logic                           locked,
    output logic                           burst_abort
);

    localparam int IDW = $clog2(NB_REQ);
    localparam int BCW = $clog2(MAX_BURST + 1);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]            state_q,  state_d;
    logic [IDW-1:0]        owner_q,  owner_d;
    logic [IDW-1:0]        prio_q,   prio_d;
    logic [BCW-1:0]        beat_q,   beat_d;
    logic                  wren_q,   wren_d;
    logic [ADDR_WIDTH-1:0] wraddr_q, wraddr_d;
    logic [DATA_WIDTH-1:0] wrdata_q, wrdata_d;
    logic [IDW-1:0]        grant_q,  grant_d;
    logic                  abort_q,  abort_d;

    // ------------------------------------------------------------------
    // Unpack the requester buses
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] w_addr_arr [NB_REQ];
    logic [DATA_WIDTH-1:0] w_data_arr [NB_REQ];

    for (genvar gi = 0; gi < NB_REQ; gi++) begin : g_unpack
        assign w_addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin successor of a requester index, wrapping at NB_REQ.
    function automatic logic [IDW-1:0] f_next(input logic [IDW-1:0] idx);
        if ({1'b0, idx} == (IDW+1)'(NB_REQ - 1))
            return '0;
        else
            return idx + IDW'(1);
    endfunction

    // ------------------------------------------------------------------
    // Round-robin pick for IDLE. The scan runs from the farthest
    // candidate back to prio, so the last hit is the first requester
    // in round-robin order.
    // ------------------------------------------------------------------
    logic           w_rr_any;
    logic [IDW-1:0] w_rr_sel;
    logic [IDW:0]   w_sum;

    always_comb begin
        w_rr_any = 1'b0;
        w_rr_sel = '0;
        w_sum    = '0;
        for (int k = NB_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, prio_q} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NB_REQ))
                w_sum = w_sum - (IDW+1)'(NB_REQ);
            if (req_valid[w_sum[IDW-1:0]]) begin
                w_rr_any = 1'b1;
                w_rr_sel = w_sum[IDW-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Ready / accept. At most one ready bit is set, so the accepted
    // requester is always w_acc_idx.
    // ------------------------------------------------------------------
    logic [IDW-1:0]    w_acc_idx;
    logic [NB_REQ-1:0] w_ready;
    logic              w_accept;
    logic              w_acc_last;

    assign w_acc_idx = (state_q == S_LOCKED) ? owner_q : w_rr_sel;

    always_comb begin
        w_ready = '0;
        if (aresetn) begin
            if (state_q == S_LOCKED || w_rr_any)
                w_ready = {{(NB_REQ-1){1'b0}}, 1'b1} << w_acc_idx;
        end
    end

    assign w_accept   = |(req_valid & w_ready);
    assign w_acc_last = req_last[w_acc_idx];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        prio_d   = prio_q;
        beat_d   = beat_q;
        abort_d  = 1'b0;
        wren_d   = w_accept;
        wraddr_d = wraddr_q;
        wrdata_d = wrdata_q;
        grant_d  = grant_q;

        if (w_accept) begin
            wraddr_d = w_addr_arr[w_acc_idx];
            wrdata_d = w_data_arr[w_acc_idx];
            grant_d  = w_acc_idx;
        end

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_acc_last) begin
                        prio_d = f_next(w_rr_sel);
                    end else begin
                        state_d = S_LOCKED;
                        owner_d = w_rr_sel;
                        beat_d  = BCW'(1);
                    end
                end
            end
            S_LOCKED: begin
                if (w_accept) begin
                    if (w_acc_last) begin
                        state_d = S_IDLE;
                        prio_d  = f_next(owner_q);
                        beat_d  = '0;
                    end else begin
`ifdef WRPORT_ARBITER_TIMEOUT_EN
                        if (beat_q + BCW'(1) == BCW'(MAX_BURST)) begin
                            state_d = S_IDLE;
                            prio_d  = f_next(owner_q);
                            beat_d  = '0;
                            abort_d = 1'b1;
                        end else begin
                            beat_d = beat_q + BCW'(1);
                        end
`else
                        // Bursts are unlimited; the count only saturates.
                        if (beat_q != BCW'(MAX_BURST))
                            beat_d = beat_q + BCW'(1);
`endif
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= S_IDLE;
            owner_q  <= '0;
            prio_q   <= '0;
            beat_q   <= '0;
            wren_q   <= 1'b0;
            wraddr_q <= '0;
            wrdata_q <= '0;
            grant_q  <= '0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            prio_q   <= prio_d;
            beat_q   <= beat_d;
            wren_q   <= wren_d;
            wraddr_q <= wraddr_d;
            wrdata_q <= wrdata_d;
            grant_q  <= grant_d;
            abort_q  <= abort_d;
        end
    end

    assign req_ready   = w_ready;
    assign wren        = wren_q;
    assign wraddr      = wraddr_q;
    assign wrdata      = wrdata_q;
    assign grant_id    = grant_q;
    assign locked      = (state_q == S_LOCKED);
    assign burst_abort = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_wrport_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wrport_arbiter
//  Purpose  : Directed self-checking bench for wrport_arbiter (NB_REQ=4,
//             8-bit address/data, MAX_BURST=4). Covers reset, round-robin
//             order, burst locking, owner stalls, reset mid-burst and the
//             burst limit when WRPORT_ARBITER_TIMEOUT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wrport_arbiter;

    localparam int NB = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [NB-1:0]     req_valid;
    logic [NB-1:0]     req_ready;
    logic [NB-1:0]     req_last;
    logic [NB*AW-1:0]  req_addr;
    logic [NB*DW-1:0]  req_data;
    logic              wren;
    logic [AW-1:0]     wraddr;
    logic [DW-1:0]     wrdata;
    logic [1:0]        grant_id;
    logic              locked;
    logic              burst_abort;

    int n_cmp = 0;
    int n_err = 0;

    always #5 aclk = ~aclk;

    wrport_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NB_REQ     (NB),
        .MAX_BURST  (4)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_last    (req_last),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .wren        (wren),
        .wraddr      (wraddr),
        .wrdata      (wrdata),
        .grant_id    (grant_id),
        .locked      (locked),
        .burst_abort (burst_abort)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_beat(input int i, input logic [7:0] a, input logic [7:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        aresetn   = 1'b0;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        tick();
        tick();
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        n_cmp++; if (wren !== 1'b0) begin n_err++; $display("FAIL reset_wren got=%b exp=0", wren); end
        n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked got=%b exp=0", locked); end
        n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
        n_cmp++; if (wraddr !== 8'h00 || wrdata !== 8'h00) begin n_err++; $display("FAIL reset_addr_data got=%h/%h exp=00/00", wraddr, wrdata); end
        n_cmp++; if (burst_abort !== 1'b0) begin n_err++; $display("FAIL reset_abort got=%b exp=0", burst_abort); end
        req_valid = 4'b0000;
        aresetn   = 1'b1;
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_round_robin();
        logic [3:0] e_rdy;
        for (int i = 0; i < NB; i++) set_beat(i, 8'h20 + 8'(i), 8'hA0 + 8'(i));
        req_last  = 4'b1111;
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 8; k++) begin
            e_rdy = 4'b0001 << (k % 4);
            n_cmp++; if (req_ready !== e_rdy) begin n_err++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, req_ready, e_rdy); end
            tick();
            n_cmp++; if (wren !== 1'b1 || grant_id !== 2'(k % 4)) begin n_err++; $display("FAIL rr_grant[%0d] got wren=%b id=%0d exp wren=1 id=%0d", k, wren, grant_id, k % 4); end
            n_cmp++; if (wraddr !== 8'h20 + 8'(k % 4) || wrdata !== 8'hA0 + 8'(k % 4)) begin n_err++; $display("FAIL rr_beat[%0d] got=%h/%h exp=%h/%h", k, wraddr, wrdata, 8'h20 + 8'(k % 4), 8'hA0 + 8'(k % 4)); end
        end
        req_valid = 4'b0000;
        tick();
        n_cmp++; if (wren !== 1'b0 || grant_id !== 2'd3 || wraddr !== 8'h23 || wrdata !== 8'hA3) begin n_err++; $display("FAIL rr_hold got wren=%b id=%0d %h/%h exp wren=0 id=3 23/a3", wren, grant_id, wraddr, wrdata); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_burst_lock();
        // single beat from req 1 moves prio to 2
        req_valid = 4'b0010;
        req_last  = 4'b1111;
        set_beat(1, 8'h01, 8'h51);
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL lock_pre_ready got=%b exp=0010", req_ready); end
        tick();
        n_cmp++; if (wren !== 1'b1 || grant_id !== 2'd1) begin n_err++; $display("FAIL lock_pre_grant got wren=%b id=%0d exp 1/1", wren, grant_id); end
        // req 2 three-beat burst while req 0 waits
        req_valid = 4'b0101;
        req_last  = 4'b0001;
        set_beat(0, 8'h0F, 8'h60);
        for (int b = 0; b < 3; b++) begin
            set_beat(2, 8'h10 + 8'(b), 8'h61 + 8'(b));
            req_last[2] = (b == 2);
            #1;
            n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL lock_ready[%0d] got=%b exp=0100", b, req_ready); end
            tick();
            n_cmp++; if (wren !== 1'b1 || grant_id !== 2'd2 || wraddr !== 8'h10 + 8'(b)) begin n_err++; $display("FAIL lock_beat[%0d] got wren=%b id=%0d addr=%h exp 1/2/%h", b, wren, grant_id, wraddr, 8'h10 + 8'(b)); end
            n_cmp++; if (locked !== (b != 2)) begin n_err++; $display("FAIL lock_state[%0d] got=%b exp=%b", b, locked, (b != 2)); end
        end
        // prio is now 3: of reqs 0 and 1, req 0 wins
        req_valid = 4'b0011;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL lock_next_ready got=%b exp=0001", req_ready); end
        tick();
        n_cmp++; if (grant_id !== 2'd0 || wraddr !== 8'h0F) begin n_err++; $display("FAIL lock_next_grant got id=%0d addr=%h exp 0/0f", grant_id, wraddr); end
        req_valid = 4'b0000;
    endtask

    // ------------------------------------------------------------------
    task automatic test_valid_drop();
        // prio is 1
        req_valid = 4'b0010;
        req_last  = 4'b0000;
        set_beat(1, 8'h30, 8'h70);
        #1;
        tick();
        n_cmp++; if (locked !== 1'b1 || grant_id !== 2'd1 || wraddr !== 8'h30) begin n_err++; $display("FAIL drop_start got lk=%b id=%0d addr=%h exp 1/1/30", locked, grant_id, wraddr); end
        // owner idle, others request with last set; last[1] set too
        req_valid = 4'b1101;
        req_last  = 4'b1111;
        #1;
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL drop_ready[%0d] got=%b exp=0010", c, req_ready); end
            tick();
            n_cmp++; if (wren !== 1'b0 || locked !== 1'b1) begin n_err++; $display("FAIL drop_hold[%0d] got wren=%b lk=%b exp 0/1", c, wren, locked); end
        end
        req_valid = 4'b0010;
        req_last  = 4'b0000;
        set_beat(1, 8'h31, 8'h71);
        #1;
        tick();
        n_cmp++; if (wren !== 1'b1 || wraddr !== 8'h31 || locked !== 1'b1) begin n_err++; $display("FAIL drop_resume got wren=%b addr=%h lk=%b exp 1/31/1", wren, wraddr, locked); end
        req_last = 4'b0010;
        set_beat(1, 8'h32, 8'h72);
        #1;
        tick();
        n_cmp++; if (wren !== 1'b1 || wraddr !== 8'h32 || wrdata !== 8'h72 || locked !== 1'b0) begin n_err++; $display("FAIL drop_end got wren=%b %h/%h lk=%b exp 1/32/72/0", wren, wraddr, wrdata, locked); end
        req_valid = 4'b0000;
        req_last  = 4'b0000;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_midburst();
        // prio is 2; only req 3 valid
        req_valid = 4'b1000;
        req_last  = 4'b0000;
        set_beat(3, 8'h40, 8'h80);
        #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL rst_mid_ready got=%b exp=1000", req_ready); end
        tick();
        n_cmp++; if (locked !== 1'b1 || wraddr !== 8'h40) begin n_err++; $display("FAIL rst_mid_beat1 got lk=%b addr=%h exp 1/40", locked, wraddr); end
        set_beat(3, 8'h41, 8'h81);
        aresetn = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_mid_ready_low got=%b exp=0000", req_ready); end
        tick();
        n_cmp++; if (wren !== 1'b0 || locked !== 1'b0 || wraddr !== 8'h00) begin n_err++; $display("FAIL rst_mid_clear got wren=%b lk=%b addr=%h exp 0/0/00", wren, locked, wraddr); end
        aresetn   = 1'b1;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        for (int i = 0; i < NB; i++) set_beat(i, 8'hC0 + 8'(i), 8'hD0 + 8'(i));
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rst_mid_after_ready got=%b exp=0001", req_ready); end
        tick();
        n_cmp++; if (wren !== 1'b1 || grant_id !== 2'd0 || wraddr !== 8'hC0) begin n_err++; $display("FAIL rst_mid_after_grant got wren=%b id=%0d addr=%h exp 1/0/c0", wren, grant_id, wraddr); end
        req_valid = 4'b0000;
    endtask

    // ------------------------------------------------------------------
    task automatic test_long_burst();
        // prio is 1; req 1 bursts with req 2 waiting
        req_valid = 4'b0110;
        req_last  = 4'b0000;
        set_beat(2, 8'h5F, 8'h9F);
`ifdef WRPORT_ARBITER_TIMEOUT_EN
        for (int b = 0; b < 4; b++) begin
            set_beat(1, 8'h50 + 8'(b), 8'h90 + 8'(b));
            #1;
            n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL to_ready[%0d] got=%b exp=0010", b, req_ready); end
            tick();
            n_cmp++; if (wren !== 1'b1 || grant_id !== 2'd1 || wraddr !== 8'h50 + 8'(b)) begin n_err++; $display("FAIL to_beat[%0d] got wren=%b id=%0d addr=%h exp 1/1/%h", b, wren, grant_id, wraddr, 8'h50 + 8'(b)); end
            n_cmp++; if (burst_abort !== (b == 3) || locked !== (b != 3)) begin n_err++; $display("FAIL to_abort[%0d] got ab=%b lk=%b exp %b/%b", b, burst_abort, locked, (b == 3), (b != 3)); end
        end
        set_beat(1, 8'h54, 8'h94);
        req_last[2] = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL to_next_ready got=%b exp=0100", req_ready); end
        tick();
        n_cmp++; if (grant_id !== 2'd2 || wraddr !== 8'h5F || burst_abort !== 1'b0) begin n_err++; $display("FAIL to_next_grant got id=%0d addr=%h ab=%b exp 2/5f/0", grant_id, wraddr, burst_abort); end
`else
        for (int b = 0; b < 6; b++) begin
            set_beat(1, 8'h50 + 8'(b), 8'h90 + 8'(b));
            req_last[1] = (b == 5);
            #1;
            n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL long_ready[%0d] got=%b exp=0010", b, req_ready); end
            tick();
            n_cmp++; if (wren !== 1'b1 || grant_id !== 2'd1 || wraddr !== 8'h50 + 8'(b)) begin n_err++; $display("FAIL long_beat[%0d] got wren=%b id=%0d addr=%h exp 1/1/%h", b, wren, grant_id, wraddr, 8'h50 + 8'(b)); end
            n_cmp++; if (burst_abort !== 1'b0 || locked !== (b != 5)) begin n_err++; $display("FAIL long_state[%0d] got ab=%b lk=%b exp 0/%b", b, burst_abort, locked, (b != 5)); end
        end
`endif
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        tick();
    endtask

    // ------------------------------------------------------------------
    initial begin
        aresetn   = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_addr  = '0;
        req_data  = '0;
        test_reset();
        test_round_robin();
        test_burst_lock();
        test_valid_drop();
        test_reset_midburst();
        test_long_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/wrport_arbiter.md
WRPORT_ARBITER -- requirements
Module: wrport_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, RAM data width.
REQ-003 SHALL have parameter NB_REQ, default 4 (range 2..16), number of requesters sharing one RAM write agent port.
REQ-004 SHALL have parameter MAX_BURST, default 16, beat limit per lock (used only under REQ-030).
REQ-005 SHALL have port aclk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port aresetn, input, 1; reset is synchronous and active-low.
REQ-007 SHALL have port req_valid, input, NB_REQ, per-requester beat valid.
REQ-008 SHALL have port req_ready, output, NB_REQ, per-requester beat accept.
REQ-009 SHALL have port req_last, input, NB_REQ, last beat of requester burst.
REQ-010 SHALL have port req_addr, input, NB_REQ*ADDR_WIDTH, packed, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 SHALL have port req_data, input, NB_REQ*DATA_WIDTH, packed likewise.
REQ-012 SHALL have ports wren (output, 1), wraddr (output, ADDR_WIDTH), wrdata (output, DATA_WIDTH), RAM write agent port.
REQ-013 SHALL have port grant_id, output, clog2(NB_REQ), requester of the beat on wren.
REQ-014 SHALL have port locked, output, 1, high while in LOCKED state.
REQ-015 SHALL have port burst_abort, output, 1, one-cycle pulse on forced release.

Function
REQ-016 SHALL implement states IDLE and LOCKED, plus registers owner, prio (round-robin pointer) and beat counter.
REQ-017 In IDLE, SHALL select first i with req_valid[i]=1 scanning prio, prio+1, ... mod NB_REQ; only that bit of req_ready is 1 (combinational from req_valid); all 0 if none valid.
REQ-018 In LOCKED, req_ready[owner] SHALL be 1 regardless of req_valid; all other bits 0.
REQ-019 A beat is accepted when req_valid[i] & req_ready[i]; at most one beat per cycle.
REQ-020 Accepted beat SHALL appear registered next cycle: wren=1, wraddr/wrdata = that beat, grant_id=i; latency exactly 1 cycle; no accept -> wren=0, wraddr/wrdata/grant_id hold.
REQ-021 IDLE accept with req_last=1: stay IDLE, prio <= (i+1) mod NB_REQ.
REQ-022 IDLE accept with req_last=0: go LOCKED, owner <= i, beat counter <= 1.
REQ-023 LOCKED accept with req_last=1: go IDLE, prio <= (owner+1) mod NB_REQ; otherwise increment beat counter.
REQ-024 Owner deasserting req_valid mid-burst SHALL NOT release the lock; no beats accepted meanwhile.
REQ-025 req_last on non-accepted cycles SHALL be ignored.
REQ-026 Arbiter SHALL never stall an accepted beat (RAM write port always ready).

Reset
REQ-027 When aresetn=0 at a clock edge: state IDLE, prio 0, owner 0, beat counter 0, wren 0, wraddr 0, wrdata 0, grant_id 0, locked 0, burst_abort 0.
REQ-028 While aresetn=0, req_ready SHALL be all 0.
REQ-029 Reset asserted mid-burst SHALL drop lock; the in-flight registered beat (wren) SHALL be cleared; no partial burst resumes.

Configuration
REQ-030 Macro WRPORT_ARBITER_TIMEOUT_EN defined: when a LOCKED accept with req_last=0 makes beat count equal MAX_BURST, SHALL go IDLE, prio <= (owner+1) mod NB_REQ, pulse burst_abort 1 cycle after that accept.
REQ-031 Macro undefined: bursts unlimited, beat counter may be omitted, burst_abort tied 0.

Verification
REQ-032 Reset, then req_valid=4'b1111, all req_last=1, held 8 cycles -> grant_id on wren sequence 0,1,2,3,0,1,2,3; wren=1 from cycle 2 onward.
REQ-033 Req 2 burst of 3 beats (addr 0x10,0x11,0x12, last on 3rd) with req 0 valid -> req 0 ready 0 throughout; wraddr 0x10,0x11,0x12 with grant_id=2; then req 0 granted, prio=3 before that grant.
REQ-034 Req 1 locked, drops valid 5 cycles mid-burst -> locked=1, wren=0, all ready 0 except bit 1; resumes and completes.
REQ-035 aresetn low during req 3 burst beat 2 -> next cycle wren=0, locked=0, prio=0; after release req 0 granted first.
REQ-036 With WRPORT_ARBITER_TIMEOUT_EN, MAX_BURST=4, req 1 sends 6 beats no last -> 4 writes, burst_abort pulses once, locked=0, req 2 (valid) granted next.
